snd_bus_seq: RTL

//  Sequences host accesses onto the shared sound-chip bus (two YM2203, one SAA1099).

---
 rtl/snd_bus_seq_pkg.sv | 31 +++
 rtl/snd_rec_cnt.sv | 28 ++
 rtl/snd_bus_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/snd_bus_seq_pkg.sv
// Shared definitions for the sound-bus sequencer: target codes, FSM states,
// default cycle constants and a helper that classifies accesses with no bus cycle.
package snd_bus_seq_pkg;

  localparam logic [1:0] TGT_YM0  = 2'b00;
  localparam logic [1:0] TGT_YM1  = 2'b01;
  localparam logic [1:0] TGT_SAA  = 2'b10;
  localparam logic [1:0] TGT_NONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREC  = 3'd1,
    ST_SETUP = 3'd2,
    ST_STRB  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int DEF_SETUP_CYC   = 1;
  localparam int DEF_STROBE_CYC  = 3;
  localparam int DEF_HOLD_CYC    = 1;
  localparam int DEF_YM_ADDR_REC = 5;
  localparam int DEF_YM_DATA_REC = 24;
  localparam int DEF_SAA_REC     = 2;
  localparam int DEF_CW          = 5;

  // The SAA1099 is write-only, so a read of it completes like an unmapped access.
  function automatic logic is_null(input logic [1:0] tgt, input logic we);
    return (tgt == TGT_NONE) || ((tgt == TGT_SAA) && !we);
  endfunction

endpackage

// File: rtl/snd_rec_cnt.sv
// Per-chip write-recovery down-counter; saturates at zero, load wins over decrement.
module snd_rec_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero,
  output logic          last
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);
  assign last = (cnt_reg == CW'(1));

endmodule

// File: rtl/snd_bus_seq.sv
// Sound-chip bus sequencer (2x YM2203, 1x SAA1099) with per-chip write recovery.
// Optional 1-entry posted-write buffer enabled by defining SNDSEQ_POSTWR_EN.
module snd_bus_seq
  import snd_bus_seq_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int YM_ADDR_REC = DEF_YM_ADDR_REC,
  parameter int YM_DATA_REC = DEF_YM_DATA_REC,
  parameter int SAA_REC     = DEF_SAA_REC,
  parameter int CW          = DEF_CW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_we,
  input  logic [1:0] req_tgt,
  input  logic       req_a0,
  input  logic [7:0] req_d,
  output logic       ack,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       ym0_cs_n,
  output logic       ym1_cs_n,
  output logic       saa_cs_n,
  output logic       bus_a0,
  output logic       bus_wr_n,
  output logic       bus_rd_n,
  output logic [7:0] bus_dout,
  output logic       bus_doe,
  input  logic [7:0] bus_din
);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STRB_LAST  = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] ph_reg, ph_next;
  logic [1:0]    tgt_reg;
  logic          we_reg, a0_reg;
  logic [7:0]    d_reg, rd_data_reg;
  logic          ack_reg, ack_next;

  logic          start, from_buf, posted;
  logic [1:0]    src_tgt;
  logic          src_we, src_a0, src_null;
  logic [7:0]    src_d;
  logic          strb_last, hold_exit, active;
  logic [2:0]    rec_zero, rec_last, rec_load;
  logic [3:0]    rec_rdy;
  logic          pbuf_full;

`ifdef SNDSEQ_POSTWR_EN
  logic       pbuf_valid_reg;
  logic [1:0] pbuf_tgt_reg;
  logic       pbuf_a0_reg;
  logic [7:0] pbuf_d_reg;
  logic       pbuf_accept;

  // Writes always pass through the buffer; reads go direct once it is empty.
  assign posted      = 1'b1;
  assign from_buf    = pbuf_valid_reg;
  assign pbuf_full   = pbuf_valid_reg;
  assign pbuf_accept = req && req_we && !pbuf_valid_reg && !ack_reg;
  assign start       = (state_reg == ST_IDLE) &&
                       (pbuf_valid_reg || (req && !req_we && !ack_reg));
  assign src_tgt     = pbuf_valid_reg ? pbuf_tgt_reg : req_tgt;
  assign src_we      = pbuf_valid_reg ? 1'b1         : req_we;
  assign src_a0      = pbuf_valid_reg ? pbuf_a0_reg  : req_a0;
  assign src_d       = pbuf_valid_reg ? pbuf_d_reg   : req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbuf_valid_reg <= 1'b0;
      pbuf_tgt_reg   <= TGT_NONE;
      pbuf_a0_reg    <= 1'b0;
      pbuf_d_reg     <= 8'h00;
    end else if (pbuf_accept) begin
      pbuf_valid_reg <= 1'b1;
      pbuf_tgt_reg   <= req_tgt;
      pbuf_a0_reg    <= req_a0;
      pbuf_d_reg     <= req_d;
    end else if (start && from_buf) begin
      pbuf_valid_reg <= 1'b0;
    end
  end
`else
  logic pbuf_accept;

  assign posted      = 1'b0;
  assign from_buf    = 1'b0;
  assign pbuf_full   = 1'b0;
  assign pbuf_accept = 1'b0;
  // The ack cycle is skipped so a request still held high is not taken twice.
  assign start       = (state_reg == ST_IDLE) && req && !ack_reg;
  assign src_tgt     = req_tgt;
  assign src_we      = req_we;
  assign src_a0      = req_a0;
  assign src_d       = req_d;
`endif

  assign src_null  = is_null(src_tgt, src_we);
  assign strb_last = (state_reg == ST_STRB) && (ph_reg == STRB_LAST);
  assign hold_exit = (state_reg == ST_HOLD) && (ph_reg == HOLD_LAST);
  // A chip may start SETUP on the cycle its counter reaches zero.
  assign rec_rdy   = {1'b1, rec_zero | rec_last};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rec
      logic [CW-1:0] load_val;
      if (gi == 2) begin : g_saa
        assign load_val = CW'(SAA_REC);
      end else begin : g_ym
        assign load_val = a0_reg ? CW'(YM_DATA_REC) : CW'(YM_ADDR_REC);
      end
      assign rec_load[gi] = hold_exit && we_reg && (tgt_reg == 2'(gi));
      snd_rec_cnt #(.CW(CW)) u_rec (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rec_load[gi]),
        .load_val (load_val),
        .zero     (rec_zero[gi]),
        .last     (rec_last[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ph_next    = ph_reg + 1'b1;
    ack_next   = pbuf_accept;
    case (state_reg)
      ST_IDLE: begin
        ph_next = '0;
        if (start) begin
          if (src_null)                ack_next   = !from_buf;
          else if (rec_rdy[src_tgt])   state_next = ST_SETUP;
          else                         state_next = ST_WREC;
        end
      end
      ST_WREC: begin
        ph_next = '0;
        if (rec_rdy[tgt_reg]) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (ph_reg == SETUP_LAST) begin
          state_next = ST_STRB;
          ph_next    = '0;
        end
      end
      ST_STRB: begin
        if (strb_last) begin
          state_next = ST_HOLD;
          ph_next    = '0;
        end
      end
      ST_HOLD: begin
        if (hold_exit) begin
          state_next = ST_IDLE;
          ph_next    = '0;
          ack_next   = !(posted && we_reg);
        end
      end
      default: begin
        state_next = ST_IDLE;
        ph_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ph_reg      <= '0;
      tgt_reg     <= TGT_NONE;
      we_reg      <= 1'b0;
      a0_reg      <= 1'b0;
      d_reg       <= 8'h00;
      ack_reg     <= 1'b0;
      rd_data_reg <= 8'hFF;
    end else begin
      state_reg <= state_next;
      ph_reg    <= ph_next;
      ack_reg   <= ack_next;
      if (start) begin
        tgt_reg <= src_tgt;
        we_reg  <= src_we;
        a0_reg  <= src_a0;
        d_reg   <= src_d;
      end
      if (start && src_null && !src_we) rd_data_reg <= 8'hFF;
      else if (strb_last && !we_reg)    rd_data_reg <= bus_din;
    end
  end

  assign active   = (state_reg == ST_SETUP) || (state_reg == ST_STRB) ||
                    (state_reg == ST_HOLD);
  assign ym0_cs_n = !(active && (tgt_reg == TGT_YM0));
  assign ym1_cs_n = !(active && (tgt_reg == TGT_YM1));
  assign saa_cs_n = !(active && (tgt_reg == TGT_SAA));
  assign bus_wr_n = !((state_reg == ST_STRB) && we_reg);
  assign bus_rd_n = !((state_reg == ST_STRB) && !we_reg);
  assign bus_doe  = active && we_reg;
  assign bus_a0   = a0_reg;
  assign bus_dout = d_reg;
  assign ack      = ack_reg;
  assign rd_data  = rd_data_reg;
  assign busy     = (state_reg != ST_IDLE) || pbuf_full;

endmodule
